// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
//   pc_sel_e       : redirect command encoding driven by the control unit
//   fetch_state_e  : fetch sequencer states
//   INST_W         : instruction word width in bits
//   INST_BYTES     : instruction word size in bytes (sequential PC step)
package inst_fetch_unit_pkg;

    localparam int INST_W     = 32;
    localparam int INST_BYTES = 4;

    typedef enum logic [1:0] {
        PC_HOLD   = 2'b00,
        PC_INC    = 2'b01,
        PC_BRANCH = 2'b10,
        PC_REG    = 2'b11
    } pc_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_REQ   = 2'b01,
        ST_VALID = 2'b10,
        ST_FAULT = 2'b11
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_unit_pc_next_calc.sv
// Combinational next-PC computation for the fetch stage.
//   pc_i        : current PC
//   pc_sel_i    : redirect command (hold / +4 / branch / register)
//   pc_mux_i    : with PC_BRANCH, 1 = PC-relative, 0 = register target
//   k_i         : signed word offset (already sign extended)
//   a_i         : register-file A bus target
//   next_pc_o   : candidate next PC (modulo 2^ADDR_W)
//   misalign_o  : candidate is not word aligned for a non-hold command
module pc_next_calc
    import inst_fetch_unit_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic [ADDR_W-1:0] pc_i,
    input  pc_sel_e           pc_sel_i,
    input  logic              pc_mux_i,
    input  logic [ADDR_W-1:0] k_i,
    input  logic [ADDR_W-1:0] a_i,
    output logic [ADDR_W-1:0] next_pc_o,
    output logic              misalign_o
);

    // Word offset converted to a byte offset; the top bits fall off, which
    // is exactly the modulo behaviour wanted for the addition below.
    logic [ADDR_W-1:0] k_bytes;
    assign k_bytes = {k_i[ADDR_W-3:0], 2'b00};

    always_comb begin
        next_pc_o = pc_i;
        unique case (pc_sel_i)
            PC_HOLD:   next_pc_o = pc_i;
            PC_INC:    next_pc_o = pc_i + ADDR_W'(INST_BYTES);
            PC_BRANCH: next_pc_o = pc_mux_i ? (pc_i + k_bytes) : a_i;
            PC_REG:    next_pc_o = a_i;
            default:   next_pc_o = pc_i;
        endcase
        misalign_o = (pc_sel_i != PC_HOLD) && (next_pc_o[1:0] != 2'b00);
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage feeding the control unit. Owns the PC, fetches one
// instruction word per redirect over a req/ack memory handshake and holds it
// until the control unit issues a non-hold PC_SEL.
//   CLK, Reset            : clock, asynchronous active-low reset
//   PC_SEL, PC_MUX, K, A  : redirect command, branch mode, word offset, target
//   Inst, InstValid, Stall: fetched word, word valid for PC, ~InstValid
//   PC, Fault             : address of Inst, sticky fetch fault
//   MemReq, MemAddr       : registered fetch request, fetch address (= PC)
//   MemAck, MemRData      : memory data return strobe and data
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int          ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int          TIMEOUT  = 255
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [1:0]        PC_SEL,
    input  logic              PC_MUX,
    input  logic [63:0]       K,
    input  logic [63:0]       A,
    output logic [INST_W-1:0] Inst,
    output logic              InstValid,
    output logic              Stall,
    output logic [ADDR_W-1:0] PC,
    output logic              Fault,
    output logic              MemReq,
    output logic [ADDR_W-1:0] MemAddr,
    input  logic              MemAck,
    input  logic [INST_W-1:0] MemRData
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [INST_W-1:0] inst_q;
    logic              valid_q;
    logic              fault_q;
    logic              req_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              misalign;

    pc_next_calc #(
        .ADDR_W (ADDR_W)
    ) u_pc_next_calc (
        .pc_i       (pc_q),
        .pc_sel_i   (pc_sel_e'(PC_SEL)),
        .pc_mux_i   (PC_MUX),
        .k_i        (K[ADDR_W-1:0]),
        .a_i        (A[ADDR_W-1:0]),
        .next_pc_o  (pc_d),
        .misalign_o (misalign)
    );

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            req_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_q <= ST_REQ;
                    req_q   <= 1'b1;
                    cnt_q   <= '0;
                end
                ST_REQ: begin
                    // An ack on the final allowed cycle still wins over timeout.
                    if (MemAck) begin
                        inst_q  <= MemRData;
                        valid_q <= 1'b1;
                        req_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ST_VALID;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        fault_q <= 1'b1;
                        req_q   <= 1'b0;
                        state_q <= ST_FAULT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_VALID: begin
                    if (pc_sel_e'(PC_SEL) != PC_HOLD) begin
                        valid_q <= 1'b0;
                        if (misalign) begin
                            // PC keeps the last good address for debug.
                            fault_q <= 1'b1;
                            state_q <= ST_FAULT;
                        end else begin
                            pc_q    <= pc_d;
                            req_q   <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= ST_REQ;
                        end
                    end
                end
                ST_FAULT: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    fault_q <= 1'b1;
                end
                default: state_q <= ST_FAULT;
            endcase
        end
    end

    assign Inst      = inst_q;
    assign InstValid = valid_q;
    assign Stall     = ~valid_q;
    assign PC        = pc_q;
    assign Fault     = fault_q;
    assign MemReq    = req_q;
    assign MemAddr   = pc_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: expected fetch addresses and
// instruction words are queued as stimulus is driven and compared when the
// DUT raises MemReq or presents a valid instruction.
module tb_inst_fetch_unit;

    localparam int ADDR_W  = 64;
    localparam int TIMEOUT = 255;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic [1:0]  PC_SEL = 2'b00;
    logic        PC_MUX = 1'b0;
    logic [63:0] K = '0;
    logic [63:0] A = '0;
    logic        MemAck = 1'b0;
    logic [31:0] MemRData = '0;
    logic [31:0] Inst;
    logic        InstValid;
    logic        Stall;
    logic [63:0] PC;
    logic        Fault;
    logic        MemReq;
    logic [63:0] MemAddr;

    inst_fetch_unit #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (64'd0),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .PC_SEL    (PC_SEL),
        .PC_MUX    (PC_MUX),
        .K         (K),
        .A         (A),
        .Inst      (Inst),
        .InstValid (InstValid),
        .Stall     (Stall),
        .PC        (PC),
        .Fault     (Fault),
        .MemReq    (MemReq),
        .MemAddr   (MemAddr),
        .MemAck    (MemAck),
        .MemRData  (MemRData)
    );

    always #5 CLK = ~CLK;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_addr_q[$];
    logic [31:0] exp_inst_q[$];
    logic [63:0] model_pc = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Called at a negedge; waits (bounded) for MemReq and scores MemAddr.
    task automatic wait_req(input string tag);
        logic [63:0] exp;
        int n = 0;
        while (MemReq !== 1'b1 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check({tag, " memreq"}, 64'(MemReq), 64'd1);
        exp = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 64'hBAD0_BAD0_BAD0_BAD0;
        check({tag, " memaddr"}, MemAddr, exp);
    endtask

    // Called at a negedge with MemReq high. PC_SEL is driven to a non-hold
    // value while waiting to show it is ignored during the request.
    task automatic serve(input int lat, input logic [31:0] data, input string tag);
        PC_SEL = 2'b11;
        A      = 64'hDEAD_0000_0000_0100;
        repeat (lat) @(negedge CLK);
        MemAck   = 1'b1;
        MemRData = data;
        exp_inst_q.push_back(data);
        @(negedge CLK);
        MemAck   = 1'b0;
        MemRData = '0;
        PC_SEL   = 2'b00;
        A        = '0;
        check({tag, " valid"}, 64'(InstValid), 64'd1);
        check({tag, " stall"}, 64'(Stall), 64'd0);
        check({tag, " memreq_low"}, 64'(MemReq), 64'd0);
        check({tag, " inst"}, 64'(Inst), 64'(exp_inst_q.pop_front()));
        check({tag, " pc"}, PC, model_pc);
    endtask

    // Called at a negedge in VALID; applies one redirect command.
    task automatic redirect(input logic [1:0] sel, input logic mux, input logic [63:0] k,
                            input logic [63:0] a, input string tag);
        logic [63:0] nxt;
        case (sel)
            2'b01:   nxt = model_pc + 64'd4;
            2'b10:   nxt = mux ? (model_pc + (k << 2)) : a;
            2'b11:   nxt = a;
            default: nxt = model_pc;
        endcase
        PC_SEL = sel;
        PC_MUX = mux;
        K      = k;
        A      = a;
        @(negedge CLK);
        PC_SEL = 2'b00;
        PC_MUX = 1'b0;
        K      = '0;
        A      = '0;
        if (nxt[1:0] != 2'b00) begin
            check({tag, " fault"}, 64'(Fault), 64'd1);
            check({tag, " memreq_low"}, 64'(MemReq), 64'd0);
            check({tag, " valid_low"}, 64'(InstValid), 64'd0);
            check({tag, " pc_kept"}, PC, model_pc);
        end else begin
            model_pc = nxt;
            exp_addr_q.push_back(nxt);
            check({tag, " valid_low"}, 64'(InstValid), 64'd0);
            check({tag, " req_latency"}, 64'(MemReq), 64'd1);
            wait_req(tag);
        end
    endtask

    task automatic do_reset();
        Reset  = 1'b0;
        PC_SEL = 2'b00;
        MemAck = 1'b0;
        repeat (2) @(negedge CLK);
        Reset    = 1'b1;
        model_pc = '0;
        exp_addr_q.delete();
        exp_inst_q.delete();
        exp_addr_q.push_back(64'd0);
        @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int req_cycles;

        // Reset state
        @(negedge CLK);
        check("rst inst", 64'(Inst), 64'd0);
        check("rst valid", 64'(InstValid), 64'd0);
        check("rst stall", 64'(Stall), 64'd1);
        check("rst memreq", 64'(MemReq), 64'd0);
        check("rst fault", 64'(Fault), 64'd0);
        check("rst pc", PC, 64'd0);

        // 1: first fetch, 2-cycle ack, then sequential step
        do_reset();
        wait_req("t1 fetch0");
        serve(2, 32'h8B02_0020, "t1 fetch0");
        redirect(2'b01, 1'b0, '0, '0, "t1 inc");
        check("t1 addr4", MemAddr, 64'd4);
        serve(0, 32'h9100_0421, "t1 fetch4");

        // 4: hold in VALID
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("t4 hold inst", 64'(Inst), 64'h9100_0421);
            check("t4 hold pc", PC, 64'd4);
            check("t4 hold valid", 64'(InstValid), 64'd1);
            check("t4 hold noreq", 64'(MemReq), 64'd0);
        end

        // 2: backward branch from 0x40
        redirect(2'b11, 1'b0, '0, 64'h40, "t2 to40");
        serve(1, 32'h1111_0040, "t2 fetch40");
        redirect(2'b10, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, '0, "t2 br");
        check("t2 pc38", PC, 64'h38);
        serve(0, 32'h2222_0038, "t2 fetch38");
        redirect(2'b10, 1'b1, 64'd3, '0, "t2 fwd");
        check("t2 pc44", PC, 64'h44);
        serve(1, 32'h3333_0044, "t2 fetch44");
        redirect(2'b10, 1'b0, 64'd7, 64'h2000, "t2 brreg");
        check("t2 pc2000", PC, 64'h2000);
        serve(3, 32'h4444_2000, "t2 fetch2000");

        // 3: register jump then misaligned jump
        redirect(2'b11, 1'b0, '0, 64'h1000, "t3 jmp");
        serve(0, 32'h5555_1000, "t3 fetch1000");
        redirect(2'b11, 1'b0, '0, 64'h1002, "t3 misalign");
        check("t3 pc1000", PC, 64'h1000);

        // 6: reset mid-request with a simultaneous ack
        do_reset();
        wait_req("t6 fetch0");
        Reset    = 1'b0;
        MemAck   = 1'b1;
        MemRData = 32'hCAFE_F00D;
        #1;
        check("t6 async memreq", 64'(MemReq), 64'd0);
        check("t6 async inst", 64'(Inst), 64'd0);
        @(negedge CLK);
        check("t6 inst", 64'(Inst), 64'd0);
        check("t6 valid", 64'(InstValid), 64'd0);
        MemAck   = 1'b0;
        MemRData = '0;
        Reset    = 1'b1;
        model_pc = '0;
        exp_addr_q.delete();
        exp_addr_q.push_back(64'd0);
        @(negedge CLK);
        wait_req("t6 restart");
        serve(1, 32'h6666_0000, "t6 restart");
        redirect(2'b11, 1'b0, '0, 64'hFFFF_FFFF_FFFF_FFFC, "t6 tomax");
        serve(0, 32'h7777_FFFC, "t6 fetchmax");
        redirect(2'b01, 1'b0, '0, '0, "t6 wrap");
        check("t6 pc0", PC, 64'd0);
        serve(0, 32'h8888_0000, "t6 fetchwrap");

        // 5: timeout, late ack ignored, fault cleared by reset only
        do_reset();
        req_cycles = 0;
        for (int i = 0; i < 1000; i++) begin
            if (Fault === 1'b1) break;
            if (MemReq === 1'b1) req_cycles++;
            @(negedge CLK);
        end
        check("t5 req_cycles", 64'(req_cycles), 64'(TIMEOUT));
        check("t5 fault", 64'(Fault), 64'd1);
        check("t5 memreq", 64'(MemReq), 64'd0);
        MemAck   = 1'b1;
        MemRData = 32'hABCD_1234;
        @(negedge CLK);
        MemAck   = 1'b0;
        MemRData = '0;
        repeat (3) @(negedge CLK);
        check("t5 late fault", 64'(Fault), 64'd1);
        check("t5 late valid", 64'(InstValid), 64'd0);
        check("t5 late inst", 64'(Inst), 64'd0);
        check("t5 late memreq", 64'(MemReq), 64'd0);
        Reset = 1'b0;
        #1;
        check("t5 reset clears fault", 64'(Fault), 64'd0);
        @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
